food_placer: RTL
================

FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 Param GRID_W, 24, playfield width in cells (1..32).
REQ-002 Param GRID_H, 16, playfield height in cells (1..32).
REQ-003 Param MAX_TRIES, 32, random candidates tried before giving up (1..255).
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port place_req  input  1  request a new food location; sampled in IDLE only.
REQ-007 Port rnd  input  5  free-running 5-bit pseudo-random value from the lsfr5 instance.
REQ-008 Port occ_req  output  1  occupancy query valid, held until occ_ack.
REQ-009 Port occ_x / occ_y  output  5 each  queried cell, stable while occ_req=1.
REQ-010 Port occ_ack  input  1  query answered this cycle.
REQ-011 Port occ_hit  input  1  cell occupied by snake; valid only with occ_ack.
REQ-012 Port food_x / food_y  output  5 each  current food cell.
REQ-013 Port food_valid  output  1  food_x/food_y hold a placed cell.
REQ-014 Port busy  output  1  placement in progress (state != IDLE).
REQ-015 Port done  output  1  one-cycle pulse when food is placed.
REQ-016 Port fail  output  1  one-cycle pulse when no free cell was found.

Function
REQ-017 States: IDLE, GET_X, GET_Y, QUERY, PLACE, FAIL; plus SCAN when FOOD_FALLBACK_SCAN_EN is defined.
REQ-018 IDLE: place_req=1 -> GET_X; clear food_valid; clear try counter; place_req outside IDLE is ignored.
REQ-019 GET_X: capture rnd into cand_x; start 5-cycle spacing counter -> GET_Y.
REQ-020 GET_Y: capture rnd into cand_y when the spacing counter expires (5 cycles after the cand_x capture) so that all five y bits are fresh LFSR outputs.
REQ-021 After the cand_y capture: if cand_x >= GRID_W or cand_y >= GRID_H, count one try and return to GET_X; otherwise go to QUERY.
REQ-022 QUERY: drive occ_req=1, occ_x=cand_x and occ_y=cand_y; wait indefinitely for occ_ack.
REQ-023 occ_ack with occ_hit=0 -> PLACE; occ_ack with occ_hit=1 -> count one try, then GET_X.
REQ-024 PLACE: load food_x/food_y, set food_valid, pulse done -> IDLE (one cycle).
REQ-025 The try counter is 8 bits; when the count reaches MAX_TRIES it moves to FAIL (macro off) or SCAN (macro on) instead of GET_X.
REQ-026 FAIL: pulse fail; food_valid stays 0 -> IDLE.
REQ-027 Latency: the fastest success takes 8 cycles from place_req to done when occ_ack returns in the first QUERY cycle.
REQ-028 occ_ack outside QUERY/SCAN is ignored.

Reset
REQ-029 reset=1 at any time, including mid-query, forces IDLE asynchronously.
REQ-030 Reset values: food_x=0, food_y=0, food_valid=0, occ_req=0, occ_x=0, occ_y=0, done=0, fail=0, busy=0, counters=0.

Configuration
REQ-031 Macro FOOD_FALLBACK_SCAN_EN.
REQ-032 Defined: SCAN steps (x,y) raster-order from (0,0), x fastest, one occupancy query per cell using the QUERY handshake; the first free cell -> PLACE; if all GRID_W*GRID_H cells are occupied -> FAIL.
REQ-033 Not defined: no SCAN state or scan counters exist; try exhaustion goes directly to FAIL.

Structure
REQ-034 Package food_pkg holds the state enum typedef, coordinate typedef (logic [4:0]) and SPACING=5 constant.
REQ-035 No sub-modules; lsfr5 is instantiated outside, at the same level as this block, and feeds rnd.

Verification
REQ-036 Out-of-range rejection: GRID_W=24; force rnd so cand_x=30 -> no occ_req, try count 1, new GET_X.
REQ-037 Free cell: occ_ack=1 and occ_hit=0 in the first QUERY cycle -> done 8 cycles after place_req, with food_x/food_y equal to the queried cell and food_valid=1.
REQ-038 Occupied every time: occ_hit=1 on every ack, MAX_TRIES=4, macro off -> exactly 4 queries, then a fail pulse, food_valid=0.
REQ-039 Same as REQ-038 with the macro on and only cell (3,2) free, GRID_W=24 -> scan ends with done, food=(3,2).
REQ-040 reset asserted while occ_req=1 and occ_ack is withheld -> occ_req=0 and busy=0 immediately; a later place_req starts cleanly.
REQ-041 place_req held high during busy -> exactly one placement; a second one starts only from IDLE.

Source files
------------

// File: rtl/food_pkg.sv
// Shared types and constants for the food placer: FSM states, coordinate type and sampling spacing.
// The SCAN state exists only when FOOD_FALLBACK_SCAN_EN is defined.
package food_pkg;

  typedef logic [4:0] coord_t;

  localparam int SPACING = 5;

`ifdef FOOD_FALLBACK_SCAN_EN
  typedef enum logic [2:0] {
    S_IDLE, S_GET_X, S_GET_Y, S_QUERY, S_PLACE, S_FAIL, S_SCAN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_GET_X, S_GET_Y, S_QUERY, S_PLACE, S_FAIL
  } state_t;
`endif

endpackage

// File: rtl/food_placer.sv
// Picks a random free playfield cell for food using an external LFSR and an occupancy query handshake.
// Optional FOOD_FALLBACK_SCAN_EN: after random tries run out, raster-scan the whole grid for a free cell.
module food_placer
  import food_pkg::*;
#(
  parameter int GRID_W    = 24,
  parameter int GRID_H    = 16,
  parameter int MAX_TRIES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place_req,
  input  logic [4:0] rnd,
  output logic       occ_req,
  output logic [4:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [4:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam logic [7:0] MAX_T = 8'(MAX_TRIES);
`ifdef FOOD_FALLBACK_SCAN_EN
  localparam state_t EXH_STATE = S_SCAN;
`else
  localparam state_t EXH_STATE = S_FAIL;
`endif

  state_t     r_state, w_next;
  coord_t     r_candX, r_candY, r_foodX, r_foodY;
  logic [2:0] r_space;
  logic [7:0] r_tries;
  logic       r_foodValid, r_done, r_fail;

  logic       w_yFire, w_outOfRange, w_retry, w_exhausted;
  logic [7:0] w_triesNext;

  // Range check uses rnd directly so the decision is made in the cand_y capture cycle.
  assign w_yFire      = (r_state == S_GET_Y) && (r_space == 3'd0);
  assign w_outOfRange = ({1'b0, r_candX} >= 6'(GRID_W)) || ({1'b0, rnd} >= 6'(GRID_H));
  assign w_retry      = (w_yFire && w_outOfRange) ||
                        ((r_state == S_QUERY) && occ_ack && occ_hit);
  assign w_triesNext  = r_tries + 8'd1;
  assign w_exhausted  = (w_triesNext == MAX_T);

`ifdef FOOD_FALLBACK_SCAN_EN
  coord_t r_scanX, r_scanY;
  logic   w_scanLast;
  assign w_scanLast = (r_scanX == 5'(GRID_W - 1)) && (r_scanY == 5'(GRID_H - 1));
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (place_req) w_next = S_GET_X;
      S_GET_X: w_next = S_GET_Y;
      S_GET_Y: if (r_space == 3'd0)
                 w_next = w_outOfRange ? (w_exhausted ? EXH_STATE : S_GET_X) : S_QUERY;
      S_QUERY: if (occ_ack)
                 w_next = occ_hit ? (w_exhausted ? EXH_STATE : S_GET_X) : S_PLACE;
      S_PLACE: w_next = S_IDLE;
      S_FAIL:  w_next = S_IDLE;
`ifdef FOOD_FALLBACK_SCAN_EN
      S_SCAN:  if (occ_ack) begin
                 if (!occ_hit)       w_next = S_PLACE;
                 else if (w_scanLast) w_next = S_FAIL;
               end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_candX     <= '0;
      r_candY     <= '0;
      r_foodX     <= '0;
      r_foodY     <= '0;
      r_space     <= '0;
      r_tries     <= '0;
      r_foodValid <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
`ifdef FOOD_FALLBACK_SCAN_EN
      r_scanX     <= '0;
      r_scanY     <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_PLACE);
      r_fail  <= (r_state == S_FAIL);
      case (r_state)
        S_IDLE: if (place_req) begin
          r_foodValid <= 1'b0;
          r_tries     <= '0;
`ifdef FOOD_FALLBACK_SCAN_EN
          r_scanX     <= '0;
          r_scanY     <= '0;
`endif
        end
        S_GET_X: begin
          r_candX <= rnd;
          r_space <= 3'(SPACING - 1);
        end
        S_GET_Y: begin
          if (r_space != 3'd0) r_space <= r_space - 3'd1;
          else                 r_candY <= rnd;
        end
        S_PLACE: begin
          r_foodX     <= r_candX;
          r_foodY     <= r_candY;
          r_foodValid <= 1'b1;
        end
`ifdef FOOD_FALLBACK_SCAN_EN
        // A free scan cell is copied into the candidate so PLACE loads it like a random hit.
        S_SCAN: if (occ_ack) begin
          if (!occ_hit) begin
            r_candX <= r_scanX;
            r_candY <= r_scanY;
          end else if (r_scanX == 5'(GRID_W - 1)) begin
            r_scanX <= '0;
            r_scanY <= r_scanY + 5'd1;
          end else begin
            r_scanX <= r_scanX + 5'd1;
          end
        end
`endif
        default: ;
      endcase
      if (w_retry) r_tries <= w_triesNext;
    end
  end

`ifdef FOOD_FALLBACK_SCAN_EN
  assign occ_req = (r_state == S_QUERY) || (r_state == S_SCAN);
  assign occ_x   = (r_state == S_SCAN) ? r_scanX : r_candX;
  assign occ_y   = (r_state == S_SCAN) ? r_scanY : r_candY;
`else
  assign occ_req = (r_state == S_QUERY);
  assign occ_x   = r_candX;
  assign occ_y   = r_candY;
`endif

  assign food_x     = r_foodX;
  assign food_y     = r_foodY;
  assign food_valid = r_foodValid;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign fail       = r_fail;

endmodule
